row_scanner: RTL

ROW_SCANNER -- requirements
Module: row_scanner

---
 rtl/row_scanner_pkg.sv | 21 ++
 rtl/row_scanner.sv | 117 +++++++++++
 2 files changed

// File: rtl/row_scanner_pkg.sv
// Shared types and default sizing for the row scanner.
// The default geometry matches a 5-to-32 row decoder.
package row_scanner_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_BLANK = 2'd2,
      S_DRIVE = 2'd3
   } state_e;

   localparam int DEF_ROWS   = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DWELL  = 1000;
   localparam int DEF_BLANK  = 4;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/row_scanner.sv
// Row scanner: walks row_addr through ROWS rows. For each row it requests the
// row data, waits for the acknowledge, blanks the decoder for BLANK cycles and
// then drives the decoder for DWELL cycles. All outputs are registered, and
// row_addr only ever moves on the same edge that takes dec_ena low, so the
// decoder never sees an address change while enabled.
module row_scanner
   import row_scanner_pkg::*;
#(
   parameter int ROWS   = DEF_ROWS,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DWELL  = DEF_DWELL,
   parameter int BLANK  = DEF_BLANK
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              row_ack,
   output logic              row_req,
   output logic [ADDR_W-1:0] row_addr,
   output logic              dec_ena,
   output logic              frame_done
);

   // One down-counter is shared by the blanking and drive phases.
   localparam int CNT_W = $clog2(max_int(DWELL, BLANK) + 1);

   localparam logic [CNT_W-1:0]  BLANK_LD = CNT_W'(BLANK - 1);
   localparam logic [CNT_W-1:0]  DWELL_LD = CNT_W'(DWELL - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] row_addr_q;
   logic [ADDR_W-1:0] row_addr_d;
   logic              row_req_q;
   logic              dec_ena_q;
   logic              frame_done_q;

   // Next row index, wrapping from the last row back to row 0.
   always_comb begin
      row_addr_d = row_addr_q + ADDR_W'(1);
      if (row_addr_q == LAST_ROW) begin
         row_addr_d = '0;
      end
   end

   // Scan FSM with the phase counter and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         row_addr_q   <= '0;
         row_req_q    <= 1'b0;
         dec_ena_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else if (!ena) begin
         // Dropping enable abandons the current row and frame outright.
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         row_addr_q   <= '0;
         row_req_q    <= 1'b0;
         dec_ena_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q    <= S_FETCH;
               row_req_q  <= 1'b1;
               row_addr_q <= '0;
            end
            S_FETCH: begin
               // frame_done marks only the first FETCH cycle, even if the ack stalls.
               frame_done_q <= 1'b0;
               if (row_ack) begin
                  state_q   <= S_BLANK;
                  row_req_q <= 1'b0;
                  cnt_q     <= BLANK_LD;
               end
            end
            S_BLANK: begin
               if (cnt_q == '0) begin
                  state_q   <= S_DRIVE;
                  dec_ena_q <= 1'b1;
                  cnt_q     <= DWELL_LD;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_DRIVE: begin
               if (cnt_q == '0) begin
                  state_q      <= S_FETCH;
                  dec_ena_q    <= 1'b0;
                  row_req_q    <= 1'b1;
                  row_addr_q   <= row_addr_d;
                  frame_done_q <= (row_addr_q == LAST_ROW);
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q      <= S_IDLE;
               cnt_q        <= '0;
               row_addr_q   <= '0;
               row_req_q    <= 1'b0;
               dec_ena_q    <= 1'b0;
               frame_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign row_req    = row_req_q;
   assign row_addr   = row_addr_q;
   assign dec_ena    = dec_ena_q;
   assign frame_done = frame_done_q;

endmodule
